// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared types and constants for the instruction fetch unit
package ifu_pkg;

  localparam int INST_W = 32;
  localparam int PC_W   = 64;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    DROP
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic              fault;
  } fetch_entry_t;

endpackage

// File: rtl/ifu_fetch_if.sv
// rtl/ifu_fetch_if.sv - memory read port between the fetch unit and instruction memory
interface ifu_fetch_if #(
  parameter int XLEN  = 64,
  parameter int BUS_W = 64
) ();

  logic             req_valid;
  logic             req_ready;
  logic [XLEN-1:0]  req_addr;
  logic             resp_valid;
  logic [BUS_W-1:0] resp_data;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  resp_valid,
    input  resp_data
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output resp_valid,
    output resp_data
  );

endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - small synchronous FIFO of fetched instruction entries
module fetch_queue
  import ifu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           wdata,
  output fetch_entry_t           rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  // Flush wins over any same-cycle push or pop.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch unit: one outstanding bus read, redirect, decode queue
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter int              BUS_W    = 64,
  parameter logic [XLEN-1:0] RESET_PC = 'h8000_0000,
  parameter int              DEPTH    = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  ifu_fetch_if.master       mem,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [XLEN-1:0]   inst_pc,
  output logic              inst_fault
);

  localparam int OFF = $clog2(BUS_W / 8);

  fetch_state_e           state, state_next;
  logic [XLEN-1:0]        pc, pc_next;
  logic                   faulted, faulted_next;
  logic                   req_valid;
  logic                   push, flush, pop;
  fetch_entry_t           push_entry, head;
  logic [$clog2(DEPTH):0] q_count;
  logic                   q_full, q_empty;
  logic [INST_W-1:0]      resp_inst;

  if (BUS_W == 64) begin : g_bus64
    assign resp_inst = pc[2] ? mem.resp_data[63:32] : mem.resp_data[31:0];
  end else begin : g_bus32
    assign resp_inst = mem.resp_data[INST_W-1:0];
  end

  assign mem.req_valid = req_valid;
  assign mem.req_addr  = {pc[XLEN-1:OFF], OFF'(0)};

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= REQ;
      pc      <= RESET_PC;
      faulted <= 1'b0;
    end else begin
      state   <= state_next;
      pc      <= pc_next;
      faulted <= faulted_next;
    end
  end

  // faulted marks a misaligned PC already reported, so fetch idles until a redirect.
  always_comb begin
    state_next   = state;
    pc_next      = pc;
    faulted_next = faulted;
    req_valid    = 1'b0;
    push         = 1'b0;
    flush        = 1'b0;
    push_entry   = '0;
    case (state)
      REQ: begin
        req_valid = !reset && !q_full && (pc[1:0] == 2'b00);
        if (req_valid && mem.req_ready) begin
          state_next = WAIT;
        end else if (!q_full && (pc[1:0] != 2'b00) && !faulted) begin
          push             = 1'b1;
          push_entry.pc    = PC_W'(pc);
          push_entry.fault = 1'b1;
          faulted_next     = 1'b1;
        end
      end
      WAIT: begin
        if (mem.resp_valid) begin
          push            = 1'b1;
          push_entry.pc   = PC_W'(pc);
          push_entry.inst = resp_inst;
          pc_next         = pc + XLEN'(4);
          state_next      = REQ;
        end
      end
      DROP: begin
        if (mem.resp_valid) state_next = REQ;
      end
      default: state_next = REQ;
    endcase

    if (redirect_valid) begin
      flush        = 1'b1;
      push         = 1'b0;
      pc_next      = redirect_pc;
      faulted_next = 1'b0;
      if (state == REQ) state_next = (req_valid && mem.req_ready) ? DROP : REQ;
      else              state_next = mem.resp_valid ? REQ : DROP;
    end
  end

  assign pop = inst_valid && inst_ready;

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (push_entry),
    .rdata (head),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  assign inst_valid = !reset && !q_empty;
  assign inst       = inst_valid ? head.inst : '0;
  assign inst_pc    = inst_valid ? head.pc[XLEN-1:0] : '0;
  assign inst_fault = inst_valid && head.fault;

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Parametrised instruction fetch unit with a valid/ready memory port, a redirect input and a small instruction queue, sitting between the PC/redirect logic and the decode stage. It holds the architectural fetch PC and issues aligned bus-word reads with at most one read outstanding. It extracts the 32-bit instruction for the current PC from each returned word and buffers it for decode. Unlike the single-cycle fetch path it replaces, it tolerates variable memory latency, decode back-pressure and mid-flight redirects.

## Interface
- `XLEN`, 64: PC/address width.
- `BUS_W`, 64: memory data width; 32 or 64 only.
- `RESET_PC`, 64'h8000_0000: PC loaded on reset.
- `DEPTH`, 2: instruction queue entries; power of two, ≥ 2.
- `clock` in 1: single clock; all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `redirect_valid` in 1: replace fetch PC this cycle.
- `redirect_pc` in XLEN: new fetch PC.
- `req_valid` out 1: memory read request.
- `req_ready` in 1: memory accepts request.
- `req_addr` out XLEN: `{pc[XLEN-1:log2(BUS_W/8)], 0}`.
- `resp_valid` in 1: read data valid; one pulse per accepted request, any latency ≥ 1 cycle.
- `resp_data` in BUS_W: read data.
- `inst_valid` out 1: queue head valid.
- `inst_ready` in 1: decode consumes head.
- `inst` out 32: instruction at head.
- `inst_pc` out XLEN: PC of head.
- `inst_fault` out 1: head is a misaligned-PC fault entry; `inst` = 0.

## Operation
- FSM states: REQ (drive `req_valid`), WAIT (request accepted, awaiting response), DROP (awaiting a response that must be discarded).
- Reset: state REQ, `pc` = RESET_PC, queue empty. Reset values: `req_valid` = 0 during reset, `inst_valid` = 0, `inst_fault` = 0, `inst` = 0, `inst_pc` = 0.
- REQ: `req_valid` = 1 only when there is queue space for the result (`count < DEPTH`) and `pc[1:0] == 0`. On `req_valid && req_ready`, go to WAIT.
- Misaligned `pc` (`pc[1:0] != 0`) in REQ with space: no request is issued. A fault entry {`pc`, inst = 0, fault = 1} is pushed, and fetch then stalls in REQ until a redirect.
- WAIT with `resp_valid`: push {`pc`, selected half, fault = 0}, set `pc` += 4, go to REQ.
- Half select for BUS_W = 64: `pc[2]` ? `resp_data[63:32]` : `resp_data[31:0]`. For BUS_W = 32, use `resp_data` directly.
- `pc` arithmetic is modulo 2^XLEN; the top address wraps to 0 silently.
- Redirect has priority over every other event in the same cycle:
  - Queue is flushed, including any same-cycle push or pop.
  - `pc` ← `redirect_pc`.
  - From REQ: stay in REQ. A request handshaking in the same cycle is treated as outstanding, so go to DROP.
  - From WAIT: go to DROP, or to REQ if `resp_valid` is high that cycle (the response is discarded).
  - From DROP: stay in DROP, or go to REQ if `resp_valid` is high.
- DROP: discard the response on `resp_valid`, then go to REQ. No request is issued while in DROP.
- Queue: `DEPTH`-entry FIFO, pop on `inst_valid && inst_ready`. Simultaneous push and pop keep the count unchanged. Push never occurs when full; this is guaranteed by the space check at request time.

## Timing
- First request: `req_valid` = 1 in the first cycle after `reset` falls, with `req_addr` = RESET_PC aligned.
- Fetch latency: `resp_valid` in cycle N gives `inst_valid` in cycle N+1 (registered queue).
- Next request: `req_valid` is asserted in cycle N+1. Peak throughput is one instruction per 2 cycles with a 1-cycle memory.
- `req_valid`/`req_addr` are held stable until `req_ready`, unless a redirect occurs.
- Redirect in cycle R: `inst_valid` = 0 in R+1. First request at the new PC in R+1 if there is no outstanding read, otherwise in the cycle after the dropped response.
- Reset asserted mid-operation: state returns to REQ and the queue empties next edge. Any in-flight memory response arriving after reset is ignored, because the FSM is in REQ, not WAIT.

## Structure
- `ifu_pkg`: `fetch_state_e` {REQ, WAIT, DROP}.
- `ifu_pkg`: `fetch_entry_t` {pc, inst, fault}.
- `ifu_pkg`: `INST_W` = 32.
- Sub-module `fetch_queue`: synchronous FIFO of `fetch_entry_t`, parameter DEPTH, with push, pop, flush, count, full and empty.

## Test plan
- **Reset / first fetch:** reset 3 cycles, memory with 1-cycle latency returning 64'h00100093_00000013. Require req_addr 0x80000000, inst 0x00000013 @0x80000000, then req_addr 0x80000000, inst 0x00100093 @0x80000004.
- **Back-pressure:** `inst_ready` = 0 for 10 cycles with DEPTH = 2. Require exactly 2 requests issued, `req_valid` = 0 afterwards, and fetch resuming one cycle after the first pop.
- **Redirect while WAIT:** 5-cycle memory latency, `redirect_pc` = 0x80001000 issued 2 cycles after the request is accepted. Require the old response discarded and no request issued until it arrives, then req_addr 0x80001000 and first inst_pc 0x80001000.
- **Redirect coincident with `resp_valid` and a queue pop:** require the queue empty, no push, and `req_valid` for the new PC in the next cycle.
- **Misaligned redirect** to 0x80000002: require one entry with `inst_fault` = 1, `inst_pc` 0x80000002, `inst` 0, and no memory request until the next redirect.
- **Wrap:** RESET_PC = 2^XLEN−4 with a 1-cycle memory. Require req_addr 2^XLEN−8, then the second fetch at pc 0 with req_addr 0.
